// File: rtl/dnn_accel_system_nios2_qsys_0_div_cell.sv
// dnn_accel_system_nios2_qsys_0_div_cell: radix-2 restoring divider, one quotient bit per cycle; `DIV_SIGNED_EN adds signed mode
module dnn_accel_system_nios2_qsys_0_div_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             M_div_start,
    input  logic             M_div_signed,
    input  logic [WIDTH-1:0] M_div_src1,
    input  logic [WIDTH-1:0] M_div_src2,
    output logic             M_div_busy,
    output logic             M_div_done,
    output logic [WIDTH-1:0] M_div_quot,
    output logic [WIDTH-1:0] M_div_rem,
    output logic             M_div_by_zero
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd3;
`ifdef DIV_SIGNED_EN
    localparam logic [1:0] FIXUP = 2'd2;
    logic sgn_q, sgn_d, neg_quot_q, neg_quot_d, neg_rem_q, neg_rem_d, a_neg, b_neg;
`else
    logic unused_signed;
    assign unused_signed = M_div_signed;
`endif
    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, quot_q, quot_d, rem_q, rem_d;
    logic             dz_q, dz_d, busy_q, busy_d, done_q, done_d, by_zero_q, by_zero_d;
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // Next-state logic: operand capture, shift/subtract iteration, sign fixup and result publish
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        r_d       = r_q;
        q_d       = q_q;
        d_d       = d_q;
        dz_d      = dz_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        quot_d    = quot_q;
        rem_d     = rem_q;
        by_zero_d = by_zero_q;
        sh        = {r_q, q_q[WIDTH-1]};
        ge        = sh >= {1'b0, d_q};
        diff      = sh[WIDTH-1:0] - d_q;
`ifdef DIV_SIGNED_EN
        sgn_d      = sgn_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        a_neg      = M_div_signed & M_div_src1[WIDTH-1];
        b_neg      = M_div_signed & M_div_src2[WIDTH-1];
`endif
        case (state_q)
            IDLE: begin
                // done_q marks the cycle of the result pulse, during which starts are ignored
                if (M_div_start && !done_q) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(WIDTH - 1);
                    r_d     = '0;
                    dz_d    = M_div_src2 == '0;
`ifdef DIV_SIGNED_EN
                    q_d        = a_neg ? -M_div_src1 : M_div_src1;
                    d_d        = b_neg ? -M_div_src2 : M_div_src2;
                    sgn_d      = M_div_signed;
                    neg_quot_d = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
`else
                    q_d = M_div_src1;
                    d_d = M_div_src2;
`endif
                end
            end
            CALC: begin
                r_d   = ge ? diff : sh[WIDTH-1:0];
                q_d   = {q_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - CW'(1);
`ifdef DIV_SIGNED_EN
                if (cnt_q == '0) state_d = sgn_q ? FIXUP : DONE;
`else
                if (cnt_q == '0) state_d = DONE;
`endif
            end
`ifdef DIV_SIGNED_EN
            FIXUP: begin
                // a zero divisor keeps the all-ones quotient; negating |src1| restores src1 as remainder
                q_d     = (neg_quot_q && !dz_q) ? -q_q : q_q;
                r_d     = neg_rem_q ? -r_q : r_q;
                state_d = DONE;
            end
`endif
            DONE: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                quot_d    = q_q;
                rem_d     = r_q;
                by_zero_d = dz_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset that aborts any operation in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            by_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q      <= 1'b0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_q       <= r_d;
            q_q       <= q_d;
            d_q       <= d_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            by_zero_q <= by_zero_d;
`ifdef DIV_SIGNED_EN
            sgn_q      <= sgn_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
`endif
        end
    end

    assign M_div_busy    = busy_q;
    assign M_div_done    = done_q;
    assign M_div_quot    = quot_q;
    assign M_div_rem     = rem_q;
    assign M_div_by_zero = by_zero_q;
endmodule
